// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with persistent NZCV flags, carry-chained
// arithmetic, compare and a multi-cycle shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int M  = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MOVA = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_result;
    logic                 r_z, r_n, r_c, r_v;
    logic                 r_out_valid;
    logic                 r_err;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_dif;
    logic [WIDTH-1:0]     w_y;
    logic                 w_c;
    logic                 w_v;
    logic                 w_wr_y;
    logic                 w_wr_c;
    logic                 w_wr_v;
    logic                 w_rsv;
    logic                 w_cin_add;
    logic                 w_cin_sub;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    // Carry/borrow-in is the flag as registered at the accept edge
    assign w_cin_add = (opcode == OP_ADC) & r_c;
    assign w_cin_sub = (opcode == OP_SBC) & r_c;
    assign w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin_add};
    assign w_dif = {1'b0, b} - {1'b0, a} - {{WIDTH{1'b0}}, w_cin_sub};

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_y    = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_wr_y = 1'b1;
        w_wr_c = 1'b0;
        w_wr_v = 1'b0;
        w_rsv  = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                w_y    = w_sum[WIDTH-1:0];
                w_c    = w_sum[WIDTH];
                w_v    = (a[M] == b[M]) && (w_y[M] != a[M]);
                w_wr_c = 1'b1;
                w_wr_v = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                w_y    = w_dif[WIDTH-1:0];
                w_c    = w_dif[WIDTH];
                w_v    = (a[M] != b[M]) && (w_y[M] != b[M]);
                w_wr_c = 1'b1;
                w_wr_v = 1'b1;
                w_wr_y = (opcode != OP_CMP);
            end
            OP_MOVA: begin
                w_y    = a;
                w_wr_c = 1'b1;
                w_wr_v = 1'b1;
            end
            OP_SHL: begin
                w_y    = {a[WIDTH-2:0], 1'b0};
                w_c    = a[M];
                w_wr_c = 1'b1;
            end
            OP_SHR: begin
                w_y    = {1'b0, a[WIDTH-1:1]};
                w_c    = a[0];
                w_wr_c = 1'b1;
            end
            OP_ASR: begin
                w_y    = {a[M], a[WIDTH-1:1]};
                w_c    = a[0];
                w_wr_c = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                w_y    = (opcode == OP_AND) ? (a & b) :
                         (opcode == OP_OR)  ? (a | b) : (a ^ b);
                w_wr_c = 1'b1;
                w_wr_v = 1'b1;
            end
            OP_MUL: begin
                w_wr_y = 1'b0;
            end
            default: begin
                w_wr_y = 1'b0;
                w_rsv  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else if (w_rsv) begin
                            r_out_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end else begin
                            r_out_valid <= 1'b1;
                            if (w_wr_y) r_result <= w_y;
                            r_z <= (w_y == '0);
                            r_n <= w_y[M];
                            if (w_wr_c) r_c <= w_c;
                            if (w_wr_v) r_v <= w_v;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    // Final iteration folds straight into the visible result
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result    <= w_acc_nxt[WIDTH-1:0];
                        r_z         <= (w_acc_nxt[WIDTH-1:0] == '0);
                        r_n         <= w_acc_nxt[M];
                        r_c         <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_v         <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign result    = r_result;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

endmodule
